seg_bcd_scan_driver: RTL and testbench

Parametrised successor to the 3-digit segment encoder. It accepts a plain binary value through a load/ready handshake and converts it to BCD with a sequential shift-add-3 (double-dabble) engine. It latches 8-bit segment codes for DIGITS digits and drives one shared segment bus with a one-hot digit-select scan. It sits between the calculator result register and the seven-segment pins.

---
 rtl/seg_bcd_scan_driver.sv | 167 ++++++++++++++++
 tb/tb_seg_bcd_scan_driver.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/seg_bcd_scan_driver.sv
// Binary-to-BCD (double-dabble) converter with latched 7-segment codes and a
// one-hot multiplexed digit scan. Optional macro LEADING_ZERO_BLANK_EN blanks leading zeros.
module seg_bcd_scan_driver #(
  parameter int DIGITS   = 3,
  parameter int DATA_W   = 10,
  parameter int SCAN_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic [DATA_W-1:0]     bin,
  output logic                  ready,
  output logic                  ovf,
  output logic [8*DIGITS-1:0]   codes,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     dig_sel
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] CONV  = 2'd1;
  localparam logic [1:0] LATCH = 2'd2;

  localparam int BW = 4 * DIGITS;
  localparam int CW = $clog2(DATA_W + 1);
  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;

  function automatic logic [63:0] pow10(input int n);
    logic [63:0] p;
    p = 64'd1;
    for (int k = 0; k < n; k++) p = p * 64'd10;
    return p;
  endfunction

  localparam logic [63:0] MAX_VAL = pow10(DIGITS) - 64'd1;

  function automatic logic [7:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 8'hFC;
      4'd1:    seg_enc = 8'h60;
      4'd2:    seg_enc = 8'hDA;
      4'd3:    seg_enc = 8'hF2;
      4'd4:    seg_enc = 8'h66;
      4'd5:    seg_enc = 8'hB6;
      4'd6:    seg_enc = 8'hBE;
      4'd7:    seg_enc = 8'hE0;
      4'd8:    seg_enc = 8'hFE;
      4'd9:    seg_enc = 8'hF6;
      default: seg_enc = 8'h00;
    endcase
  endfunction

  logic [1:0]           state;
  logic [DATA_W-1:0]    shreg;
  logic [BW-1:0]        bcd;
  logic [BW-1:0]        bcd_adj;
  logic [BW+DATA_W-1:0] shifted;
  logic [CW-1:0]        cnt;
  logic                 ovf_pend;
  logic [8*DIGITS-1:0]  latch_codes;
  logic [3:0]           nib;
  logic [PW-1:0]        presc;
  logic                 wrap;
  logic [DIGITS-1:0]    dig_next;
  logic [7:0]           seg_next;
`ifdef LEADING_ZERO_BLANK_EN
  logic                 lead;
`endif

  // NOTE: combinational blocks use blocking '=' and assign every output a
  // default first, so no latch is inferred; clocked blocks use '<=' only.
  always_comb begin
    bcd_adj = '0;
    for (int i = 0; i < DIGITS; i++)
      bcd_adj[4*i +: 4] = (bcd[4*i +: 4] >= 4'd5) ? bcd[4*i +: 4] + 4'd3 : bcd[4*i +: 4];
    shifted = {bcd_adj, shreg} << 1;
  end

  // Walk from the top digit down so leading zeros can be detected in one pass.
  always_comb begin
    latch_codes = '0;
    nib         = 4'd0;
`ifdef LEADING_ZERO_BLANK_EN
    lead        = 1'b1;
`endif
    for (int i = DIGITS - 1; i >= 0; i--) begin
      nib = bcd[4*i +: 4];
      if (ovf_pend) begin
        latch_codes[8*i +: 8] = 8'h02;
      end else begin
`ifdef LEADING_ZERO_BLANK_EN
        if (lead && nib == 4'd0 && i != 0) begin
          latch_codes[8*i +: 8] = 8'h00;
        end else begin
          latch_codes[8*i +: 8] = seg_enc(nib);
          lead = 1'b0;
        end
`else
        latch_codes[8*i +: 8] = seg_enc(nib);
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      ready    <= 1'b1;
      ovf      <= 1'b0;
      ovf_pend <= 1'b0;
      codes    <= '0;
      shreg    <= '0;
      bcd      <= '0;
      cnt      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (load) begin
            shreg    <= bin;
            bcd      <= '0;
            cnt      <= CW'(DATA_W);
            ovf_pend <= (64'(bin) > MAX_VAL);
            ready    <= 1'b0;
            state    <= CONV;
          end
        end
        CONV: begin
          bcd   <= shifted[BW+DATA_W-1:DATA_W];
          shreg <= shifted[DATA_W-1:0];
          cnt   <= cnt - CW'(1);
          if (cnt == CW'(1)) state <= LATCH;
        end
        LATCH: begin
          codes <= latch_codes;
          ovf   <= ovf_pend;
          ready <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Scan path: seg is loaded with the slice of the digit that dig_sel selects
  // after this same edge, so both outputs always agree.
  always_comb begin
    wrap     = (presc == PW'(SCAN_DIV - 1));
    dig_next = dig_sel;
    if (wrap)
      for (int i = 0; i < DIGITS; i++) dig_next[i] = dig_sel[(i + DIGITS - 1) % DIGITS];
    seg_next = 8'h00;
    for (int i = 0; i < DIGITS; i++)
      if (dig_next[i]) seg_next = codes[8*i +: 8];
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      presc   <= '0;
      dig_sel <= DIGITS'(1);
      seg     <= 8'h00;
    end else begin
      presc   <= wrap ? '0 : presc + PW'(1);
      dig_sel <= dig_next;
      seg     <= seg_next;
    end
  end

endmodule

// File: tb/tb_seg_bcd_scan_driver.sv
// Directed self-checking bench for seg_bcd_scan_driver (DIGITS=3, DATA_W=10, SCAN_DIV=4).
module tb_seg_bcd_scan_driver;

  localparam int DIGITS   = 3;
  localparam int DATA_W   = 10;
  localparam int SCAN_DIV = 4;

  logic                clk = 1'b0;
  logic                rst;
  logic                load;
  logic [DATA_W-1:0]   bin;
  logic                ready;
  logic                ovf;
  logic [8*DIGITS-1:0] codes;
  logic [7:0]          seg;
  logic [DIGITS-1:0]   dig_sel;

  int n_cmp = 0;
  int n_bad = 0;

  seg_bcd_scan_driver #(.DIGITS(DIGITS), .DATA_W(DATA_W), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .load(load), .bin(bin), .ready(ready), .ovf(ovf),
    .codes(codes), .seg(seg), .dig_sel(dig_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one load while idle, then run to the edge where results appear.
  task automatic convert(input logic [DATA_W-1:0] v);
    check("ready_before_load", 64'(ready), 64'd1);
    load = 1'b1;
    bin  = v;
    tick();
    load = 1'b0;
    bin  = '0;
    for (int k = 0; k < DATA_W; k++) tick();
    tick();
  endtask

  logic found;

  initial begin
    rst  = 1'b0;
    load = 1'b0;
    bin  = '0;
    #1;
    tick();
    tick();
    rst = 1'b1;
    check("rst_ready",   64'(ready),   64'd1);
    check("rst_ovf",     64'(ovf),     64'd0);
    check("rst_codes",   64'(codes),   64'h0);
    check("rst_dig_sel", 64'(dig_sel), 64'b001);
    check("rst_seg",     64'(seg),     64'h00);

    // Latency: load at edge N, ready low through N+10, results at N+11.
    load = 1'b1;
    bin  = 10'd999;
    tick();
    load = 1'b0;
    check("lat_ready_N", 64'(ready), 64'd0);
    for (int k = 1; k <= 10; k++) begin
      tick();
      check("lat_ready_busy", 64'(ready), 64'd0);
      check("lat_codes_hold", 64'(codes), 64'h0);
    end
    tick();
    check("lat_ready_N11", 64'(ready), 64'd1);
    check("c999_codes",    64'(codes), 64'hF6F6F6);
    check("c999_ovf",      64'(ovf),   64'd0);

`ifdef LEADING_ZERO_BLANK_EN
    convert(10'd0);
    check("c0_codes", 64'(codes), 64'h0000FC);
    convert(10'd42);
    check("c42_codes", 64'(codes), 64'h0066DA);
`else
    convert(10'd0);
    check("c0_codes", 64'(codes), 64'hFCFCFC);
    convert(10'd42);
    check("c42_codes", 64'(codes), 64'hFC66DA);
`endif

    convert(10'd1000);
    check("c1000_codes", 64'(codes), 64'h020202);
    check("c1000_ovf",   64'(ovf),   64'd1);
    convert(10'd1023);
    check("c1023_codes", 64'(codes), 64'h020202);
    check("c1023_ovf",   64'(ovf),   64'd1);

    convert(10'd7);
    check("c7_ovf", 64'(ovf), 64'd0);
`ifdef LEADING_ZERO_BLANK_EN
    check("c7_codes", 64'(codes), 64'h0000E0);
`else
    check("c7_codes", 64'(codes), 64'hFCFCE0);
`endif

    // Second load while busy must be ignored.
    load = 1'b1;
    bin  = 10'd123;
    tick();
    load = 1'b0;
    tick();
    tick();
    load = 1'b1;
    bin  = 10'd456;
    for (int k = 3; k <= 5; k++) begin
      tick();
      check("busy_ready_low", 64'(ready), 64'd0);
    end
    load = 1'b0;
    bin  = '0;
    for (int k = 6; k <= 10; k++) begin
      tick();
      check("busy_ready_low", 64'(ready), 64'd0);
    end
    tick();
    check("c123_ready", 64'(ready), 64'd1);
    check("c123_codes", 64'(codes), 64'h60DAF2);
    check("c123_ovf",   64'(ovf),   64'd0);
    tick();
    tick();
    check("c123_still_idle_codes", 64'(codes), 64'h60DAF2);

    // Scan: find the edge where dig_sel returns to digit 0, then step through.
    found = 1'b0;
    for (int k = 0; k < 20 && !found; k++) begin
      logic [DIGITS-1:0] prev;
      prev = dig_sel;
      tick();
      if (prev != 3'b001 && dig_sel == 3'b001) found = 1'b1;
    end
    check("scan_sync_found", 64'(found), 64'd1);
    check("scan0_sel", 64'(dig_sel), 64'b001);
    check("scan0_seg", 64'(seg),     64'hF2);
    for (int k = 0; k < 3; k++) tick();
    check("scan0_hold_sel", 64'(dig_sel), 64'b001);
    tick();
    check("scan1_sel", 64'(dig_sel), 64'b010);
    check("scan1_seg", 64'(seg),     64'hDA);
    for (int k = 0; k < 4; k++) tick();
    check("scan2_sel", 64'(dig_sel), 64'b100);
    check("scan2_seg", 64'(seg),     64'h60);
    for (int k = 0; k < 4; k++) tick();
    check("scan3_sel", 64'(dig_sel), 64'b001);
    check("scan3_seg", 64'(seg),     64'hF2);

    // Reset in the middle of a conversion.
    load = 1'b1;
    bin  = 10'd555;
    tick();
    load = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    check("midconv_ready", 64'(ready), 64'd0);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    check("midrst_ready",   64'(ready),   64'd1);
    check("midrst_codes",   64'(codes),   64'h0);
    check("midrst_dig_sel", 64'(dig_sel), 64'b001);
    check("midrst_seg",     64'(seg),     64'h00);
    check("midrst_ovf",     64'(ovf),     64'd0);

    convert(10'd865);
    check("c865_codes", 64'(codes), 64'hFEBEB6);
    check("c865_ovf",   64'(ovf),   64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
